// File: rtl/bist_scan_sequencer.sv
// Scan-BIST session sequencer: drives TPG/MISR/CUT controls through seed, shift/capture, unload and signature compare.
// Optional diagnostics outputs (diag_pattern, diag_sig) are enabled by defining BIST_SEQ_DIAG_EN.
module bist_scan_sequencer #(
    parameter int unsigned      CHAIN_LEN    = 16,
    parameter int unsigned      NUM_PATTERNS = 100,
    parameter int unsigned      SIG_W        = 12,
    parameter logic [SIG_W-1:0] GOLDEN       = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             abort,
    input  logic [SIG_W-1:0] signature,
    output logic             scan_en,
    output logic             tpg_sel,
    output logic             seed_load,
    output logic             misr_clr,
    output logic             misr_en,
    output logic             running,
    output logic             bist_end,
    output logic             pass_fail
`ifdef BIST_SEQ_DIAG_EN
    ,
    output logic [((NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1)-1:0] diag_pattern,
    output logic [SIG_W-1:0] diag_sig
`endif
);

    localparam int unsigned SW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam int unsigned PW = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1;
    localparam logic [SW-1:0] SHIFT_LAST = SW'(CHAIN_LEN - 1);
    localparam logic [PW-1:0] PAT_LAST   = PW'(NUM_PATTERNS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_SHIFT,
        S_CAPTURE,
        S_UNLOAD,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [SW-1:0] shift_cnt;
    logic [PW-1:0] pat_cnt;

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (start) state_nxt = S_INIT;
                S_INIT:    state_nxt = S_SHIFT;
                S_SHIFT:   if (shift_cnt == SHIFT_LAST) state_nxt = S_CAPTURE;
                S_CAPTURE: state_nxt = (pat_cnt == PAT_LAST) ? S_UNLOAD : S_SHIFT;
                S_UNLOAD:  if (shift_cnt == SHIFT_LAST) state_nxt = S_COMPARE;
                S_COMPARE: state_nxt = S_DONE;
                S_DONE:    if (start) state_nxt = S_INIT;
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= S_IDLE;
            shift_cnt <= '0;
            pat_cnt   <= '0;
            scan_en   <= 1'b0;
            tpg_sel   <= 1'b0;
            seed_load <= 1'b0;
            misr_clr  <= 1'b0;
            misr_en   <= 1'b0;
            running   <= 1'b0;
            bist_end  <= 1'b0;
            pass_fail <= 1'b0;
`ifdef BIST_SEQ_DIAG_EN
            diag_sig  <= '0;
`endif
        end else begin
            state     <= state_nxt;
            scan_en   <= (state_nxt == S_SHIFT) || (state_nxt == S_UNLOAD);
            tpg_sel   <= state_nxt inside {S_INIT, S_SHIFT, S_CAPTURE, S_UNLOAD};
            seed_load <= (state_nxt == S_INIT);
            misr_clr  <= (state_nxt == S_INIT);
            misr_en   <= state_nxt inside {S_SHIFT, S_CAPTURE, S_UNLOAD};
            running   <= state_nxt inside {S_INIT, S_SHIFT, S_CAPTURE, S_UNLOAD, S_COMPARE};
            bist_end  <= (state_nxt == S_DONE);

            if (state_nxt != S_DONE) begin
                pass_fail <= 1'b0;
            end else if (state == S_COMPARE) begin
                pass_fail <= (signature == GOLDEN);
            end

            // shift_cnt restarts at 0 on every entry into SHIFT or UNLOAD
            if ((state_nxt == S_SHIFT || state_nxt == S_UNLOAD) && state_nxt == state) begin
                shift_cnt <= shift_cnt + SW'(1);
            end else begin
                shift_cnt <= '0;
            end

            if (state_nxt == S_INIT || state_nxt == S_IDLE) begin
                pat_cnt <= '0;
            end else if (state == S_CAPTURE && state_nxt == S_SHIFT) begin
                pat_cnt <= pat_cnt + PW'(1);
            end

`ifdef BIST_SEQ_DIAG_EN
            if (state_nxt == S_INIT || state_nxt == S_IDLE) begin
                diag_sig <= '0;
            end else if (state == S_COMPARE && state_nxt == S_DONE) begin
                diag_sig <= signature;
            end
`endif
        end
    end

`ifdef BIST_SEQ_DIAG_EN
    assign diag_pattern = pat_cnt;
`endif

endmodule

// File: tb/tb_bist_scan_sequencer.sv
// Self-checking bench for bist_scan_sequencer; expected outputs come from a cycle-index timeline of the session.
`timescale 1ns/1ps
module tb_bist_scan_sequencer;

    localparam int C  = 4;
    localparam int P  = 3;
    localparam int W  = 12;
    localparam int PW = 2;
    localparam logic [W-1:0] GOLD = 12'h5A3;
    localparam int BODY   = P * (C + 1);
    localparam int CMP    = BODY + C + 1;
    localparam int DONE_K = CMP + 1;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] signature = '0;
    logic scan_en, tpg_sel, seed_load, misr_clr, misr_en, running, bist_end, pass_fail;
`ifdef BIST_SEQ_DIAG_EN
    logic [PW-1:0] diag_pattern;
    logic [W-1:0]  diag_sig;
`endif
    logic [6:0] obs;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    assign obs = {scan_en, tpg_sel, seed_load, misr_clr, misr_en, running, bist_end};

    bist_scan_sequencer #(
        .CHAIN_LEN(C),
        .NUM_PATTERNS(P),
        .SIG_W(W),
        .GOLDEN(GOLD)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .start(start),
        .abort(abort),
        .signature(signature),
        .scan_en(scan_en),
        .tpg_sel(tpg_sel),
        .seed_load(seed_load),
        .misr_clr(misr_clr),
        .misr_en(misr_en),
        .running(running),
        .bist_end(bist_end),
        .pass_fail(pass_fail)
`ifdef BIST_SEQ_DIAG_EN
        ,
        .diag_pattern(diag_pattern),
        .diag_sig(diag_sig)
`endif
    );

    // k = cycles since the edge that sampled start (k<0: idle, k>=DONE_K: done).
    // Bits: {scan_en, tpg_sel, seed_load, misr_clr, misr_en, running, bist_end}
    function automatic logic [6:0] model(input int k);
        if (k < 0) return 7'b0000000;
        if (k == 0) return 7'b0111010;
        if (k <= BODY) return (((k - 1) % (C + 1)) < C) ? 7'b1100110 : 7'b0100110;
        if (k <= BODY + C) return 7'b1100110;
        if (k == CMP) return 7'b0000010;
        return 7'b0000001;
    endfunction

    function automatic int model_pat(input int k);
        if (k <= 0) return 0;
        if (k <= BODY) return (k - 1) / (C + 1);
        return P - 1;
    endfunction

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        #1 RST = 1'b0;
        #2;
        checks++;
        if (obs !== 7'b0 || pass_fail !== 1'b0) begin
            errors++;
            $display("FAIL reset_async outs=%b pf=%b expected outs=0000000 pf=0", obs, pass_fail);
        end
        tick();
        RST = 1'b1;
        start = 1'b1;
        abort = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 1) begin
                start = 1'b0;
                abort = 1'b0;
            end
            checks++;
            if (obs !== 7'b0 || pass_fail !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle i=%0d outs=%b pf=%b expected outs=0000000 pf=0", i, obs, pass_fail);
            end
        end
    endtask

    task automatic test_basic(input logic [W-1:0] cmp_sig, input string tag);
        int   scan_total = 0;
        int   first_end = -1;
        logic exp_pf;
        start = 1'b1;
        for (int k = 0; k <= DONE_K + 2; k++) begin
            tick();
            if (k == 0) start = 1'b0;
            exp_pf = (k >= DONE_K) && (cmp_sig == GOLD);
            checks++;
            if (obs !== model(k) || pass_fail !== exp_pf) begin
                errors++;
                $display("FAIL %s k=%0d outs=%b pf=%b expected outs=%b pf=%b", tag, k, obs, pass_fail, model(k), exp_pf);
            end
`ifdef BIST_SEQ_DIAG_EN
            checks++;
            if (diag_pattern !== PW'(model_pat(k)) || diag_sig !== ((k >= DONE_K) ? cmp_sig : '0)) begin
                errors++;
                $display("FAIL %s_diag k=%0d pat=%0d sig=%h expected pat=%0d sig=%h", tag, k, diag_pattern, diag_sig,
                         model_pat(k), (k >= DONE_K) ? cmp_sig : '0);
            end
`endif
            if (scan_en) scan_total++;
            if (bist_end && first_end < 0) first_end = k;
            signature = (k == CMP) ? cmp_sig : W'($urandom);
        end
        checks++;
        if (scan_total != (P + 1) * C) begin
            errors++;
            $display("FAIL %s_scan_total got=%0d expected=%0d", tag, scan_total, (P + 1) * C);
        end
        checks++;
        if (first_end != DONE_K) begin
            errors++;
            $display("FAIL %s_end_edge got=%0d expected=%0d", tag, first_end, DONE_K);
        end
    endtask

    task automatic test_abort(input int abort_k, input logic [W-1:0] cmp_sig, input string tag);
        int   ek;
        logic exp_pf;
        start = 1'b1;
        for (int k = 0; k <= abort_k + 3; k++) begin
            tick();
            if (k == 0) start = 1'b0;
            ek = (k > abort_k) ? -1 : k;
            exp_pf = (ek >= DONE_K) && (cmp_sig == GOLD);
            checks++;
            if (obs !== model(ek) || pass_fail !== exp_pf) begin
                errors++;
                $display("FAIL %s k=%0d outs=%b pf=%b expected outs=%b pf=%b", tag, k, obs, pass_fail, model(ek), exp_pf);
            end
            signature = (k == CMP) ? cmp_sig : W'($urandom);
            // abort wins over a simultaneous start, in any state
            if (k == abort_k) begin
                abort = 1'b1;
                start = 1'b1;
            end
        end
        abort = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_back_to_back;
        int   ek;
        logic exp_pf;
        start = 1'b1;
        for (int k = 0; k <= DONE_K + 4; k++) begin
            tick();
            ek = (k <= DONE_K) ? k : k - DONE_K - 1;
            exp_pf = (k == DONE_K);
            checks++;
            if (obs !== model(ek) || pass_fail !== exp_pf) begin
                errors++;
                $display("FAIL back_to_back k=%0d outs=%b pf=%b expected outs=%b pf=%b", k, obs, pass_fail, model(ek), exp_pf);
            end
            signature = (k == CMP) ? GOLD : W'($urandom);
        end
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (obs !== 7'b0 || pass_fail !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_abort outs=%b pf=%b expected outs=0000000 pf=0", obs, pass_fail);
        end
    endtask

    task automatic test_async_reset;
        start = 1'b1;
        for (int k = 0; k <= BODY + 2; k++) begin
            tick();
            if (k == 0) start = 1'b0;
            checks++;
            if (obs !== model(k)) begin
                errors++;
                $display("FAIL async_pre k=%0d outs=%b expected outs=%b", k, obs, model(k));
            end
        end
        #3 RST = 1'b0;
        #1;
        checks++;
        if (obs !== 7'b0 || pass_fail !== 1'b0) begin
            errors++;
            $display("FAIL async_reset outs=%b pf=%b expected outs=0000000 pf=0", obs, pass_fail);
        end
        tick();
        tick();
        RST = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (obs !== 7'b0 || pass_fail !== 1'b0) begin
                errors++;
                $display("FAIL async_idle i=%0d outs=%b pf=%b expected outs=0000000 pf=0", i, obs, pass_fail);
            end
        end
    endtask

    task automatic test_random;
        int           ek = -1;
        int           prev;
        logic [W-1:0] cap = '0;
        logic         exp_pf;
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick();
            prev = ek;
            if (abort) ek = -1;
            else if (ek < 0) ek = start ? 0 : -1;
            else if (ek >= DONE_K) ek = start ? 0 : DONE_K;
            else ek = ek + 1;
            if (prev == CMP && ek == DONE_K) cap = signature;
            exp_pf = (ek >= DONE_K) && (cap == GOLD);
            checks++;
            if (obs !== model(ek) || pass_fail !== exp_pf) begin
                errors++;
                $display("FAIL random i=%0d k=%0d outs=%b pf=%b expected outs=%b pf=%b", i, ek, obs, pass_fail, model(ek), exp_pf);
            end
`ifdef BIST_SEQ_DIAG_EN
            checks++;
            if (diag_pattern !== PW'(model_pat(ek)) || diag_sig !== ((ek >= DONE_K) ? cap : '0)) begin
                errors++;
                $display("FAIL random_diag i=%0d pat=%0d sig=%h expected pat=%0d sig=%h", i, diag_pattern, diag_sig,
                         model_pat(ek), (ek >= DONE_K) ? cap : '0);
            end
`endif
            start = ($urandom_range(0, 7) == 0);
            abort = ($urandom_range(0, 39) == 0);
            signature = (ek == CMP && $urandom_range(0, 1) == 1) ? GOLD : W'($urandom);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic(GOLD ^ 12'h001, "session_fail");
        test_basic(GOLD, "session_pass");
        test_abort(7, GOLD, "abort_shift");
        test_basic(GOLD, "after_abort");
        test_abort(DONE_K + 1, GOLD, "abort_done");
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
